onehot_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the one-hot state register and drives its 3-bit cmd input. It buffers commands from a valid/ready producer in a small FIFO. Each command is held on cmd until the downstream one-hot state changes or a timeout expires, and commands are separated by one idle cycle. It watches the downstream state vector and flags illegal (non-one-hot) encodings.

---
 rtl/onehot_pkg.sv | 22 ++
 rtl/onehot_cmd_seq_chk.sv | 38 +++
 rtl/onehot_cmd_seq_fifo.sv | 71 +++++++
 rtl/onehot_cmd_seq.sv | 135 +++++++++++++
 tb/tb_onehot_cmd_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot command sequencer slice.
package onehot_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } seq_state_e;

  localparam logic [CMD_W-1:0] CMD_NOP = 3'b000;
  localparam logic [CMD_W-1:0] CMD_ADV = 3'b001;
  localparam logic [CMD_W-1:0] CMD_BR  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_EXT = 3'b100;

  // Vectors narrower than 64 bits are zero-extended by the caller.
  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/onehot_cmd_seq_chk.sv
// Protocol checker bound into the sequencer; simulation-only properties.
module onehot_cmd_seq_chk
  import onehot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic [1:0]       i_fsm,
  input logic [CMD_W-1:0] i_cmd,
  input logic             i_timeout_err,
  input logic [CW-1:0]    i_count,
  input logic             i_push,
  input logic             i_pop,
  input logic             i_full,
  input logic             i_empty
);

  a_cmd_only_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
    (i_cmd != CMD_NOP) |-> (i_fsm == ISSUE));

  a_cmd_zero_after_issue: assert property (@(posedge clk) disable iff (!rst_n)
    ((i_fsm != ISSUE) && ($past(i_fsm) == ISSUE)) |-> (i_cmd == CMD_NOP));

  a_tmo_from_issue: assert property (@(posedge clk) disable iff (!rst_n)
    i_timeout_err |-> ($past(i_fsm) == ISSUE));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (i_count <= CW'(DEPTH)));

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && i_full));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && i_empty));

endmodule

// File: rtl/onehot_cmd_seq_fifo.sv
// Command FIFO: power-of-two depth, registered count, head-of-queue read.
module cmd_fifo
  import onehot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Requests are qualified here as a second line of defence against overflow/underflow.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, cleared on reset so discarded commands cannot resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

endmodule

// File: rtl/onehot_cmd_seq.sv
// Sequencer feeding the one-hot state register: FIFO-buffered commands held
// until the state moves or a timeout expires, with an illegal-encoding monitor.
module onehot_cmd_seq
  import onehot_pkg::*;
#(
  parameter int N       = 6,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  input  logic [CMD_W-1:0] i_req_cmd,
  output logic             o_req_ready,
  input  logic [N-1:0]     i_state,
  output logic [CMD_W-1:0] o_cmd,
  output logic             o_busy,
  output logic             o_timeout_err,
  output logic             o_illegal_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_e       r_fsm;
  logic [CMD_W-1:0] r_cmd;
  logic [N-1:0]     r_snap;
  logic [TW-1:0]    r_timer;
  logic             r_timeout_err;
  logic             r_illegal;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CMD_W-1:0] w_head;
  logic             w_changed;
  logic             w_expired;

  // Ready comes only from the registered count, so a same-cycle pop never frees a slot.
  assign o_req_ready = !w_full;
  assign w_push      = i_req_valid && !w_full;
  assign w_changed   = (i_state != r_snap);
  assign w_expired   = (r_timer == TW'(TIMEOUT - 1));
  assign w_pop       = (r_fsm == ISSUE) && (w_changed || w_expired);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (i_req_cmd),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Issue FSM: a state change takes priority over timeout when both land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm         <= IDLE;
      r_cmd         <= CMD_NOP;
      r_snap        <= '0;
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_fsm)
        IDLE, GAP: begin
          if (!w_empty) begin
            r_fsm   <= ISSUE;
            r_cmd   <= w_head;
            r_snap  <= i_state;
            r_timer <= '0;
          end else begin
            r_fsm <= IDLE;
            r_cmd <= CMD_NOP;
          end
        end
        ISSUE: begin
          if (w_changed) begin
            r_fsm <= GAP;
            r_cmd <= CMD_NOP;
          end else if (w_expired) begin
            r_fsm         <= GAP;
            r_cmd         <= CMD_NOP;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_fsm <= IDLE;
          r_cmd <= CMD_NOP;
        end
      endcase
    end
  end

  // Encoding monitor runs every cycle regardless of what the sequencer is doing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= !is_onehot(64'(i_state));
    end
  end

  assign o_cmd           = r_cmd;
  assign o_timeout_err   = r_timeout_err;
  assign o_illegal_state = r_illegal;
  assign o_busy          = (w_count != '0) || (r_fsm != IDLE);

  onehot_cmd_seq_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_fsm         (r_fsm),
    .i_cmd         (r_cmd),
    .i_timeout_err (r_timeout_err),
    .i_count       (w_count),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_full        (w_full),
    .i_empty       (w_empty)
  );

endmodule

// File: tb/tb_onehot_cmd_seq.sv
// Directed bench for onehot_cmd_seq: hand-computed per-cycle expectations.
module tb_onehot_cmd_seq;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_cmd;
  logic       req_ready;
  logic [5:0] state;
  logic [2:0] cmd;
  logic       busy;
  logic       timeout_err;
  logic       illegal_state;

  int n_cmp;
  int n_bad;

  onehot_cmd_seq #(.N(6), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_valid     (req_valid),
    .i_req_cmd       (req_cmd),
    .o_req_ready     (req_ready),
    .i_state         (state),
    .o_cmd           (cmd),
    .o_busy          (busy),
    .o_timeout_err   (timeout_err),
    .o_illegal_state (illegal_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] seq_cmds [5];
    seq_cmds[0] = 3'b001;
    seq_cmds[1] = 3'b010;
    seq_cmds[2] = 3'b100;
    seq_cmds[3] = 3'b011;
    seq_cmds[4] = 3'b101;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 3'b000;
    state     = 6'b000001;

    // Reset values
    step();
    chk("rst_cmd", 8'(cmd), 8'h0);
    chk("rst_ready", 8'(req_ready), 8'h1);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_tmo", 8'(timeout_err), 8'h0);
    chk("rst_ill", 8'(illegal_state), 8'h0);
    rst_n = 1'b1;

    // 1: idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_cmd", 8'(cmd), 8'h0);
      chk("idle_busy", 8'(busy), 8'h0);
      chk("idle_ready", 8'(req_ready), 8'h1);
    end

    // 2: single command retired by state change (t0)
    req_valid = 1'b1;
    req_cmd   = 3'b001;
    step();                                   // t0+1
    req_valid = 1'b0;
    chk("sc_cmd_t1", 8'(cmd), 8'h0);
    chk("sc_busy_t1", 8'(busy), 8'h1);
    step();                                   // t0+2
    chk("sc_cmd_t2", 8'(cmd), 8'h1);
    step();                                   // t0+3
    chk("sc_cmd_t3", 8'(cmd), 8'h1);
    state = 6'b000010;
    step();                                   // t0+4 GAP
    chk("sc_gap_cmd", 8'(cmd), 8'h0);
    chk("sc_gap_busy", 8'(busy), 8'h1);
    chk("sc_gap_tmo", 8'(timeout_err), 8'h0);
    step();                                   // t0+5 IDLE
    chk("sc_idle_busy", 8'(busy), 8'h0);
    chk("sc_idle_cmd", 8'(cmd), 8'h0);

    // 3: timeout with frozen state (u0)
    req_valid = 1'b1;
    req_cmd   = 3'b100;
    step();                                   // u0+1
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();                                 // u0+2 .. u0+16
      chk("to_hold_cmd", 8'(cmd), 8'h4);
      chk("to_hold_tmo", 8'(timeout_err), 8'h0);
    end
    step();                                   // u0+17 GAP
    chk("to_gap_cmd", 8'(cmd), 8'h0);
    chk("to_gap_tmo", 8'(timeout_err), 8'h1);
    step();                                   // u0+18
    chk("to_after_tmo", 8'(timeout_err), 8'h0);
    chk("to_after_busy", 8'(busy), 8'h0);

    // 5: state change exactly at timer==TIMEOUT-1 (v0)
    req_valid = 1'b1;
    req_cmd   = 3'b010;
    step();                                   // v0+1
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();                                 // v0+2 .. v0+16
      chk("sim_hold_cmd", 8'(cmd), 8'h2);
    end
    state = 6'b000100;
    step();                                   // v0+17 GAP
    chk("sim_gap_cmd", 8'(cmd), 8'h0);
    chk("sim_gap_tmo", 8'(timeout_err), 8'h0);
    step();
    chk("sim_idle_busy", 8'(busy), 8'h0);

    // 4: FIFO fill with frozen state (w0)
    req_valid = 1'b1;
    req_cmd   = seq_cmds[0];
    step();                                   // w0+1
    chk("ff_ready_1", 8'(req_ready), 8'h1);
    req_cmd = seq_cmds[1];
    step();                                   // w0+2
    chk("ff_ready_2", 8'(req_ready), 8'h1);
    chk("ff_issue_a", 8'(cmd), 8'h1);
    req_cmd = seq_cmds[2];
    step();                                   // w0+3
    chk("ff_ready_3", 8'(req_ready), 8'h1);
    req_cmd = seq_cmds[3];
    step();                                   // w0+4 count=4
    chk("ff_ready_full", 8'(req_ready), 8'h0);
    req_cmd = seq_cmds[4];
    for (int i = 5; i <= 16; i++) begin
      step();                                 // w0+5 .. w0+16
      chk("ff_stall_ready", 8'(req_ready), 8'h0);
      chk("ff_stall_cmd", 8'(cmd), 8'h1);
    end
    step();                                   // w0+17 GAP, slot freed
    chk("ff_pop_ready", 8'(req_ready), 8'h1);
    chk("ff_gap_a_cmd", 8'(cmd), 8'h0);
    chk("ff_gap_a_tmo", 8'(timeout_err), 8'h1);
    step();                                   // w0+18 B issued, E stored
    req_valid = 1'b0;
    chk("ff_refull_ready", 8'(req_ready), 8'h0);
    for (int j = 1; j < 5; j++) begin
      for (int c = 0; c < 15; c++) begin
        chk("ff_order_cmd", 8'(cmd), 8'(seq_cmds[j]));
        step();
      end
      chk("ff_gap_cmd", 8'(cmd), 8'h0);
      chk("ff_gap_tmo", 8'(timeout_err), 8'h1);
      step();
    end
    chk("ff_drain_busy", 8'(busy), 8'h0);
    chk("ff_drain_ready", 8'(req_ready), 8'h1);

    // 6a: illegal state detection
    state = 6'b000110;
    step();
    chk("ill_set", 8'(illegal_state), 8'h1);
    state = 6'b000001;
    step();
    chk("ill_clr", 8'(illegal_state), 8'h0);

    // 6b: asynchronous reset during ISSUE
    req_valid = 1'b1;
    req_cmd   = 3'b011;
    step();
    req_cmd = 3'b001;
    step();
    req_valid = 1'b0;
    chk("ar_issue_cmd", 8'(cmd), 8'h3);
    step();
    chk("ar_issue_busy", 8'(busy), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cmd", 8'(cmd), 8'h0);
    chk("ar_busy", 8'(busy), 8'h0);
    chk("ar_ready", 8'(req_ready), 8'h1);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("ar_post_cmd", 8'(cmd), 8'h0);
    chk("ar_post_busy", 8'(busy), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
